// File: rtl/spi_adc_rx.sv
// -----------------------------------------------------------------------------
// spi_adc_rx
// SPI mode-0 master receiver: reads one DataWidth-bit sample from a serial ADC
// for each accepted start request. Asserts chip select, runs the serial clock,
// shifts in MISO MSB-first on every sclk rising edge and presents the word
// with a one-cycle valid strobe when chip select is released.
//
// Ports
//   clk_i    in   system clock, all logic on rising edge
//   rst_i    in   asynchronous active-high reset
//   start_i  in   request one frame, only honoured in IDLE
//   miso_i   in   serial data from the ADC
//   sclk_o   out  SPI clock, idle low
//   cs_n_o   out  chip select, active low
//   data_o   out  last received word, MSB = first bit on the wire
//   valid_o  out  one-cycle strobe when data_o is updated
//   busy_o   out  high from start acceptance until the CS quiet time ends
//
// State  | meaning
// IDLE   | waiting for start_i, CS high, sclk low
// SETUP  | CS low, ClkDiv cycles before the first sclk rise
// SHIFT  | sclk toggling, MISO captured on each rise
// DONE   | CS high quiet time, valid_o on its first cycle
// -----------------------------------------------------------------------------
module spi_adc_rx #(
    parameter int DataWidth = 16,
    parameter int ClkDiv    = 4,
    parameter int CntWidth  = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 miso_i,
    output logic                 sclk_o,
    output logic                 cs_n_o,
    output logic [DataWidth-1:0] data_o,
    output logic                 valid_o,
    output logic                 busy_o
);

    localparam int DivWidth = (ClkDiv > 2) ? $clog2(ClkDiv) : 1;
    localparam logic [DivWidth-1:0] DivLast  = DivWidth'(ClkDiv - 1);
    localparam logic [CntWidth-1:0] BitsLast = CntWidth'(DataWidth);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DivWidth-1:0]   div_q, div_d;
    logic [CntWidth-1:0]   bit_q, bit_d;
    logic [DataWidth-1:0]  shift_q, shift_d;
    logic [DataWidth-1:0]  data_d;
    logic                  sclk_d, cs_n_d, valid_d, busy_d;
    logic                  div_wrap;

    assign div_wrap = (div_q == DivLast);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_o  <= '0;
            sclk_o  <= 1'b0;
            cs_n_o  <= 1'b1;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_o  <= data_d;
            sclk_o  <= sclk_d;
            cs_n_o  <= cs_n_d;
            valid_o <= valid_d;
            busy_o  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_o;
        sclk_d  = sclk_o;
        cs_n_d  = cs_n_o;
        valid_d = 1'b0;
        busy_d  = busy_o;

        unique case (state_q)
            IDLE: begin
                div_d = '0;
                if (start_i) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            SETUP: begin
                if (div_wrap) begin
                    // First sclk rise coincides with leaving SETUP, so the
                    // first bit is captured here rather than in SHIFT.
                    div_d   = '0;
                    state_d = SHIFT;
                    sclk_d  = 1'b1;
                    shift_d = (shift_q << 1) | DataWidth'(miso_i);
                    bit_d   = bit_q + CntWidth'(1);
                end else begin
                    div_d = div_q + DivWidth'(1);
                end
            end

            SHIFT: begin
                if (div_wrap) begin
                    div_d = '0;
                    if (sclk_o) begin
                        sclk_d = 1'b0;
                    end else if (bit_q == BitsLast) begin
                        // Final low phase has elapsed: release CS and publish.
                        state_d = DONE;
                        cs_n_d  = 1'b1;
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        sclk_d  = 1'b1;
                        shift_d = (shift_q << 1) | DataWidth'(miso_i);
                        bit_d   = bit_q + CntWidth'(1);
                    end
                end else begin
                    div_d = div_q + DivWidth'(1);
                end
            end

            DONE: begin
                if (div_wrap) begin
                    div_d   = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    bit_d   = '0;
                end else begin
                    div_d = div_q + DivWidth'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_adc_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_adc_rx
// Bench for spi_adc_rx. A default-parameter instance is checked every cycle
// against a frame-timeline model (outputs derived from the cycle offset since
// start acceptance); a ClkDiv=2 / DataWidth=12 instance gets directed checks.
// ADC models present the next bit on each sclk falling edge.
// -----------------------------------------------------------------------------
module tb_spi_adc_rx;

    localparam int W          = 16;
    localparam int CD         = 4;
    localparam int FRAME      = (2 * W + 2) * CD;   // 136
    localparam int DONE_AT    = (2 * W + 1) * CD;   // 132
    localparam int LAST_FALL  = 2 * W * CD;         // 128

    localparam int W2         = 12;
    localparam int CD2        = 2;

    logic clk = 1'b0;
    logic rst;
    logic start, miso;
    logic sclk, cs_n, valid, busy;
    logic [W-1:0] data;

    logic start2, miso2;
    logic sclk2, cs_n2, valid2, busy2;
    logic [W2-1:0] data2;

    always #5 clk = ~clk;

    spi_adc_rx #(.DataWidth(W), .ClkDiv(CD), .CntWidth(5)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .miso_i(miso),
        .sclk_o(sclk), .cs_n_o(cs_n), .data_o(data), .valid_o(valid), .busy_o(busy)
    );

    spi_adc_rx #(.DataWidth(W2), .ClkDiv(CD2), .CntWidth(4)) u_var (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .miso_i(miso2),
        .sclk_o(sclk2), .cs_n_o(cs_n2), .data_o(data2), .valid_o(valid2), .busy_o(busy2)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ADC models
    logic [W-1:0]  adc_word = '0, adc_cur = '0;
    int            adc_idx = W;
    logic [W2-1:0] adc2_word = '0, adc2_cur = '0;
    int            adc2_idx = W2;

    always @(negedge cs_n) begin
        adc_cur = adc_word;
        adc_idx = 0;
        miso    = adc_cur[W-1];
    end
    always @(negedge sclk) begin
        if (adc_idx < W - 1) begin
            adc_idx++;
            miso = adc_cur[W-1-adc_idx];
        end
    end

    always @(negedge cs_n2) begin
        adc2_cur = adc2_word;
        adc2_idx = 0;
        miso2    = adc2_cur[W2-1];
    end
    always @(negedge sclk2) begin
        if (adc2_idx < W2 - 1) begin
            adc2_idx++;
            miso2 = adc2_cur[W2-1-adc2_idx];
        end
    end

    // Timeline model: m_n is the number of edges since the accepting edge.
    bit           m_active = 1'b0;
    int           m_n      = 0;
    logic [W-1:0] m_word   = '0;
    logic [W-1:0] m_data   = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_n      = 0;
            m_data   = '0;
        end else if (m_active) begin
            m_n++;
            if (m_n == DONE_AT) m_data = m_word;
            if (m_n == FRAME)   m_active = 1'b0;
        end else if (start) begin
            m_active = 1'b1;
            m_n      = 0;
            m_word   = adc_word;
        end
    end

    always @(negedge clk) begin
        logic e_sclk;
        e_sclk = m_active && (m_n >= CD) && (m_n < LAST_FALL) && (((m_n - CD) / CD) % 2 == 0);
        chk("busy",  busy,  m_active);
        chk("cs_n",  cs_n,  !(m_active && m_n < DONE_AT));
        chk("sclk",  sclk,  e_sclk);
        chk("valid", valid, m_active && m_n == DONE_AT);
        chk("data",  data,  m_data);
    end

    // Event recorders
    logic [W-1:0] vq[$];
    int           vcyc = 0, bfall = 0, rcnt = 0;
    int           acq[$];
    bit           busy_prev = 1'b0, cs_prev = 1'b1;
    int           v2cnt = 0, v2cyc = 0, b2fall = 0, r2cnt = 0;
    logic [W2-1:0] v2data = '0;
    bit           busy2_prev = 1'b0;

    always @(posedge sclk)  rcnt++;
    always @(posedge sclk2) r2cnt++;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vq.push_back(data);
            vcyc = cyc;
        end
        if (busy_prev && busy === 1'b0) bfall = cyc;
        busy_prev = (busy === 1'b1);
        if (cs_prev && cs_n === 1'b0) acq.push_back(cyc);
        cs_prev = (cs_n !== 1'b0);
        if (valid2 === 1'b1) begin
            v2cnt++;
            v2cyc  = cyc;
            v2data = data2;
        end
        if (busy2_prev && busy2 === 1'b0) b2fall = cyc;
        busy2_prev = (busy2 === 1'b1);
    end

    task automatic pulse_start(output int c0);
        @(posedge clk);
        #1 start = 1'b1;
        c0 = cyc + 1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_sclk",  sclk,  1'b0);
        chk("rst_cs_n",  cs_n,  1'b1);
        chk("rst_busy",  busy,  1'b0);
        chk("rst_data",  data,  16'h0000);
        chk("rst_valid", valid, 1'b0);

        // Basic read
        adc_word = 16'hA5C3; vq.delete(); rcnt = 0;
        pulse_start(c0);
        wait_until(c0 + 150);
        chk("basic_nvalid", vq.size(), 1);
        if (vq.size() > 0) chk("basic_data", vq[0], 16'hA5C3);
        chk("basic_valid_at", vcyc - c0, 132);
        chk("basic_busy_fall", bfall - c0, 136);
        chk("basic_rises", rcnt, 16);
        chk("basic_hold", data, 16'hA5C3);

        // Extremes back-to-back
        adc_word = 16'h0000; vq.delete(); acq.delete();
        @(posedge clk);
        #1 start = 1'b1;
        c0 = cyc + 1;
        wait_until(c0 + 1);
        adc_word = 16'hFFFF;
        wait_until(c0 + 137);
        start = 1'b0;
        wait_until(c0 + 290);
        chk("ext_nvalid", vq.size(), 2);
        if (vq.size() == 2) begin
            chk("ext_data0", vq[0], 16'h0000);
            chk("ext_data1", vq[1], 16'hFFFF);
        end
        chk("ext_nframes", acq.size(), 2);

        // Start while busy
        adc_word = 16'h5A5A; vq.delete(); acq.delete();
        pulse_start(c0);
        wait_until(c0 + 49);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_until(c0 + 160);
        chk("busy_nvalid", vq.size(), 1);
        chk("busy_nframes", acq.size(), 1);
        chk("busy_fall", bfall - c0, 136);

        // Continuous start across three frames
        adc_word = 16'h1111; vq.delete(); acq.delete();
        @(posedge clk);
        #1 start = 1'b1;
        c0 = cyc + 1;
        wait_until(c0 + 1);
        adc_word = 16'h2222;
        wait_until(c0 + 138);
        adc_word = 16'h3333;
        wait_until(c0 + 274);
        start = 1'b0;
        wait_until(c0 + 420);
        chk("cont_nframes", acq.size(), 3);
        if (acq.size() == 3) begin
            chk("cont_start0", acq[0] - c0, 0);
            chk("cont_start1", acq[1] - c0, 137);
            chk("cont_start2", acq[2] - c0, 274);
        end
        chk("cont_nvalid", vq.size(), 3);
        if (vq.size() == 3) begin
            chk("cont_data0", vq[0], 16'h1111);
            chk("cont_data1", vq[1], 16'h2222);
            chk("cont_data2", vq[2], 16'h3333);
        end

        // Reset mid-frame
        adc_word = 16'h7777; vq.delete();
        pulse_start(c0);
        wait_until(c0 + 60);
        rst = 1'b1;
        #1;
        chk("mrst_sclk", sclk, 1'b0);
        chk("mrst_cs_n", cs_n, 1'b1);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_data", data, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        chk("mrst_nvalid", vq.size(), 0);
        adc_word = 16'h1234;
        pulse_start(c0);
        wait_until(c0 + 150);
        chk("post_nvalid", vq.size(), 1);
        if (vq.size() > 0) chk("post_data", vq[0], 16'h1234);

        // Narrow/fast variant: valid lands (2*DataWidth+1)*ClkDiv after accept
        adc2_word = 12'hABC; r2cnt = 0;
        @(posedge clk);
        #1 start2 = 1'b1;
        c0 = cyc + 1;
        @(posedge clk);
        #1 start2 = 1'b0;
        wait_until(c0 + 80);
        chk("var_nvalid", v2cnt, 1);
        chk("var_data", v2data, 12'hABC);
        chk("var_valid_at", v2cyc - c0, 50);
        chk("var_busy_fall", b2fall - c0, 52);
        chk("var_rises", r2cnt, 12);
        chk("var_sclk_idle", sclk2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
